// File: rtl/vga_rx_pkg.sv
// Shared timing defaults, FSM encoding, error bit map and the CRC step used
// by the VGA receive monitor.
package vga_rx_pkg;

  localparam int unsigned H_ACTIVE_D = 640;
  localparam int unsigned H_FP_D     = 16;
  localparam int unsigned H_SYNC_D   = 96;
  localparam int unsigned H_BP_D     = 48;
  localparam int unsigned V_ACTIVE_D = 480;
  localparam int unsigned V_FP_D     = 10;
  localparam int unsigned V_SYNC_D   = 2;
  localparam int unsigned V_BP_D     = 33;

  localparam int unsigned H_TOTAL_D  = H_SYNC_D + H_BP_D + H_ACTIVE_D + H_FP_D;
  localparam int unsigned V_TOTAL_D  = V_SYNC_D + V_BP_D + V_ACTIVE_D + V_FP_D;
  localparam int unsigned H_OFF_D    = H_SYNC_D + H_BP_D;
  localparam int unsigned V_OFF_D    = V_SYNC_D + V_BP_D;

  localparam int unsigned CNT_W      = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int unsigned LIT_W      = 19;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

  localparam int unsigned ERR_HS_PER = 0;
  localparam int unsigned ERR_HS_WID = 1;
  localparam int unsigned ERR_VS_PER = 2;

  // CRC-16-CCITT advanced by one 12-bit word, MSB first.
  function automatic logic [15:0] crc16_12(input logic [15:0] crc, input logic [11:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_frame_crc.sv
// Per-frame lit-pixel counter and CRC accumulator; latch publishes the
// running values and restarts accumulation in the same cycle.
module vga_frame_crc
  import vga_rx_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_init,
  input  logic             i_latch,
  input  logic [11:0]      i_rgb,
  output logic [LIT_W-1:0] o_lit_count,
  output logic [15:0]      o_crc,
  output logic             o_done
);

  logic [LIT_W-1:0] r_lit_acc;
  logic [15:0]      r_crc_acc;
  logic [LIT_W-1:0] r_lit_out;
  logic [15:0]      r_crc_out;
  logic             r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lit_acc <= '0;
      r_crc_acc <= CRC_INIT;
      r_lit_out <= '0;
      r_crc_out <= CRC_INIT;
      r_done    <= 1'b0;
    end else begin
      r_done <= i_latch;
      if (i_latch) begin
        r_lit_out <= r_lit_acc;
        r_crc_out <= r_crc_acc;
      end
      if (i_init || i_latch) begin
        r_lit_acc <= '0;
        r_crc_acc <= CRC_INIT;
      end else if (i_en) begin
        r_lit_acc <= r_lit_acc + {{(LIT_W-1){1'b0}}, |i_rgb};
        r_crc_acc <= crc16_12(r_crc_acc, i_rgb);
      end
    end
  end

  assign o_lit_count = r_lit_out;
  assign o_crc       = r_crc_out;
  assign o_done      = r_done;

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: recovers pixel coordinates from sync edges, checks sync
// timing, and reports per-frame lit count and CRC once locked.
module vga_rx_monitor
  import vga_rx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_D,
  parameter int unsigned H_FP     = H_FP_D,
  parameter int unsigned H_SYNC   = H_SYNC_D,
  parameter int unsigned H_BP     = H_BP_D,
  parameter int unsigned V_ACTIVE = V_ACTIVE_D,
  parameter int unsigned V_FP     = V_FP_D,
  parameter int unsigned V_SYNC   = V_SYNC_D,
  parameter int unsigned V_BP     = V_BP_D
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pix_stb_i,
  input  logic             hs_i,
  input  logic             vs_i,
  input  logic [3:0]       r_i,
  input  logic [3:0]       g_i,
  input  logic [3:0]       b_i,
  output logic [9:0]       x_o,
  output logic [8:0]       y_o,
  output logic [11:0]      rgb_o,
  output logic             pix_valid_o,
  output logic             locked_o,
  output logic             frame_done_o,
  output logic [LIT_W-1:0] lit_count_o,
  output logic [15:0]      crc_o,
  output logic [2:0]       err_o
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SW     = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] HA_START = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] HA_END   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] VA_START = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] VA_END   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [8:0]       VA_OFF9  = 9'(V_SYNC + V_BP);

  logic [1:0]       r_hs_sync, r_vs_sync;
  logic [11:0]      r_rgb_d1, r_rgb_d2;
  logic             r_hs_prev, r_vs_prev;
  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
  rx_state_e        r_state, w_state_nxt;
  logic             r_first_hs, r_hs_err_frame;
  logic [2:0]       r_err;
  logic [9:0]       r_x;
  logic [8:0]       r_y;
  logic [11:0]      r_rgb;
  logic             r_pix_valid;

  logic             w_hs, w_vs;
  logic             w_hs_fall, w_hs_rise, w_vs_fall;
  logic [CNT_W-1:0] w_h_inc, w_v_inc, w_h_now, w_v_now;
  logic             w_checking;
  logic [2:0]       w_err_now;
  logic             w_hs_err;
  logic             w_active;
  logic [9:0]       w_x;
  logic [8:0]       w_y;
  logic             w_acc_init, w_acc_latch;

  // RGB rides a 2-flop delay matching the sync synchroniser so that colour
  // and recovered position stay aligned regardless of strobe spacing.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hs_sync <= 2'b11;
      r_vs_sync <= 2'b11;
      r_rgb_d1  <= '0;
      r_rgb_d2  <= '0;
    end else begin
      r_hs_sync <= {r_hs_sync[0], hs_i};
      r_vs_sync <= {r_vs_sync[0], vs_i};
      r_rgb_d1  <= {r_i, g_i, b_i};
      r_rgb_d2  <= r_rgb_d1;
    end
  end

  assign w_hs      = r_hs_sync[1];
  assign w_vs      = r_vs_sync[1];
  assign w_hs_fall = pix_stb_i &  r_hs_prev & ~w_hs;
  assign w_hs_rise = pix_stb_i & ~r_hs_prev &  w_hs;
  assign w_vs_fall = pix_stb_i &  r_vs_prev & ~w_vs;

  // w_h_now / w_v_now are the coordinates of the current strobe.
  assign w_h_inc = (r_h_cnt == CNT_MAX) ? r_h_cnt : r_h_cnt + 1'b1;
  assign w_v_inc = (r_v_cnt == CNT_MAX) ? r_v_cnt : r_v_cnt + 1'b1;
  assign w_h_now = w_hs_fall ? '0 : w_h_inc;
  assign w_v_now = w_vs_fall ? '0 : (w_hs_fall ? w_v_inc : r_v_cnt);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hs_prev <= 1'b1;
      r_vs_prev <= 1'b1;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
    end else if (pix_stb_i) begin
      r_hs_prev <= w_hs;
      r_vs_prev <= w_vs;
      r_h_cnt   <= w_h_now;
      r_v_cnt   <= w_v_now;
    end
  end

  assign w_checking             = (r_state != SEARCH);
  assign w_err_now[ERR_HS_PER]  = w_checking & w_hs_fall & ~r_first_hs & (r_h_cnt != H_LAST);
  assign w_err_now[ERR_HS_WID]  = w_checking & w_hs_rise & (w_h_now != H_SW);
  assign w_err_now[ERR_VS_PER]  = w_checking & w_vs_fall & (r_v_cnt != V_LAST);
  assign w_hs_err               = w_err_now[ERR_HS_PER] | w_err_now[ERR_HS_WID];

  always_comb begin
    w_state_nxt = r_state;
    w_acc_init  = 1'b0;
    w_acc_latch = 1'b0;
    case (r_state)
      SEARCH: if (w_vs_fall) w_state_nxt = ALIGN;
      ALIGN: begin
        if (w_vs_fall && !w_err_now[ERR_VS_PER] && !r_hs_err_frame && !w_hs_err) begin
          w_state_nxt = LOCKED;
          w_acc_init  = 1'b1;
        end
      end
      LOCKED: begin
        if (|w_err_now)     w_state_nxt = SEARCH;
        else if (w_vs_fall) w_acc_latch = 1'b1;
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state        <= SEARCH;
      r_first_hs     <= 1'b1;
      r_hs_err_frame <= 1'b0;
      r_err          <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= r_err | w_err_now;
      if (r_state == SEARCH) r_first_hs <= 1'b1;
      else if (w_hs_fall)    r_first_hs <= 1'b0;
      if (r_state != ALIGN || w_vs_fall) r_hs_err_frame <= 1'b0;
      else if (w_hs_err)                 r_hs_err_frame <= 1'b1;
    end
  end

  assign w_active = (r_state == LOCKED) & pix_stb_i &
                    (w_h_now >= HA_START) & (w_h_now < HA_END) &
                    (w_v_now >= VA_START) & (w_v_now < VA_END);
  assign w_x      = w_h_now - HA_START;
  assign w_y      = w_v_now[8:0] - VA_OFF9;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pix_valid <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_rgb       <= '0;
    end else begin
      r_pix_valid <= w_active;
      if (w_active) begin
        r_x   <= w_x;
        r_y   <= w_y;
        r_rgb <= r_rgb_d2;
      end
    end
  end

  vga_frame_crc u_frame_crc (
    .i_clk       (clk_i),
    .i_rst_n     (rst_i),
    .i_en        (w_active),
    .i_init      (w_acc_init),
    .i_latch     (w_acc_latch),
    .i_rgb       (r_rgb_d2),
    .o_lit_count (lit_count_o),
    .o_crc       (crc_o),
    .o_done      (frame_done_o)
  );

  assign x_o         = r_x;
  assign y_o         = r_y;
  assign rgb_o       = r_rgb;
  assign pix_valid_o = r_pix_valid;
  assign locked_o    = (r_state == LOCKED);
  assign err_o       = r_err;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a shrunken raster (17x9 totals,
// 8x4 active) so that many frames fit in a short run.
module tb_vga_rx_monitor;

  localparam int HA = 8, HF = 2, HSW = 4, HB = 3;
  localparam int VA = 4, VF = 1, VSW = 2, VB = 2;
  localparam int HT = HSW + HB + HA + HF;
  localparam int VT = VSW + VB + VA + VF;
  localparam int HOFF = HSW + HB;
  localparam int VOFF = VSW + VB;

  logic        clk, rst_n, stb, hs, vs;
  logic [3:0]  r, g, b;
  logic [9:0]  x_o;
  logic [8:0]  y_o;
  logic [11:0] rgb_o;
  logic        pix_valid_o, locked_o, frame_done_o;
  logic [18:0] lit_count_o;
  logic [15:0] crc_o;
  logic [2:0]  err_o;

  int checks = 0;
  int errors = 0;
  int pv_cnt = 0;
  int fd_cnt = 0;
  int nz_cnt = 0;
  logic [9:0]  nz_x = '0;
  logic [8:0]  nz_y = '0;
  logic [11:0] nz_rgb = '0;

  vga_rx_monitor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .pix_stb_i(stb), .hs_i(hs), .vs_i(vs),
    .r_i(r), .g_i(g), .b_i(b),
    .x_o(x_o), .y_o(y_o), .rgb_o(rgb_o), .pix_valid_o(pix_valid_o),
    .locked_o(locked_o), .frame_done_o(frame_done_o),
    .lit_count_o(lit_count_o), .crc_o(crc_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pix_valid_o) begin
      pv_cnt <= pv_cnt + 1;
      if (rgb_o != 12'h000) begin
        nz_cnt <= nz_cnt + 1;
        nz_x   <= x_o;
        nz_y   <= y_o;
        nz_rgb <= rgb_o;
      end
    end
    if (frame_done_o) fd_cnt <= fd_cnt + 1;
  end

  function automatic logic [11:0] col(input int mode, input int x, input int y);
    case (mode)
      1:       return 12'hFFF;
      2:       return (x == HA - 1 && y == VA - 1) ? 12'hF00 : 12'h000;
      3:       return {4'(x + 1), 4'(y), 4'hA};
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] s;
    logic        fb;
    s = c;
    for (int k = 11; k >= 0; k--) begin
      fb = s[15] ^ d[k];
      s  = s << 1;
      if (fb) s = s ^ 16'h1021;
    end
    return s;
  endfunction

  function automatic logic [15:0] model_crc(input int mode);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int yy = 0; yy < VA; yy++)
      for (int xx = 0; xx < HA; xx++)
        c = crc_step(c, col(mode, xx, yy));
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_line(input int v, input int h0, input int h1, input int hsw, input int mode);
    logic [11:0] c;
    for (int h = h0; h < h1; h++) begin
      @(negedge clk);
      hs = (h >= hsw);
      vs = (v >= VSW);
      if (h >= HOFF && h < HOFF + HA && v >= VOFF && v < VOFF + VA)
        c = col(mode, h - HOFF, v - VOFF);
      else
        c = 12'h000;
      {r, g, b} = c;
      stb = 1'b1;
      @(negedge clk);
      stb = 1'b0;
    end
  endtask

  task automatic send_frame(input int mode, input int nlines, input int short_ln, input int narrow_ln);
    for (int v = 0; v < nlines; v++)
      send_line(v, 0, (v == short_ln) ? HT - 1 : HT, (v == narrow_ln) ? HSW - 1 : HSW, mode);
  endtask

  initial begin
    int pv0, fd0, nz0;
    rst_n = 1'b0; stb = 1'b0; hs = 1'b1; vs = 1'b1; r = '0; g = '0; b = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_x", x_o, 0);
    chk("rst_y", y_o, 0);
    chk("rst_rgb", rgb_o, 0);
    chk("rst_pv", pix_valid_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_fd", frame_done_o, 0);
    chk("rst_lit", lit_count_o, 0);
    chk("rst_crc", crc_o, 16'hFFFF);
    chk("rst_err", err_o, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_frame(0, VT, -1, -1);                 // F0: acquisition
    #1; chk("f0_locked", locked_o, 0);
    pv0 = pv_cnt;
    send_frame(0, VT, -1, -1);                 // F1: lock at its VS edge
    #1;
    chk("f1_locked", locked_o, 1);
    chk("f1_pv", pv_cnt - pv0, HA * VA);
    chk("f1_fd", fd_cnt, 0);
    pv0 = pv_cnt;
    send_frame(0, VT, -1, -1);                 // F2: reports F1
    #1;
    chk("f2_fd", fd_cnt, 1);
    chk("f2_lit", lit_count_o, 0);
    chk("f2_crc", crc_o, model_crc(0));
    chk("f2_pv", pv_cnt - pv0, HA * VA);

    pv0 = pv_cnt;
    repeat (20) @(negedge clk);
    #1;
    chk("idle_pv", pv_cnt - pv0, 0);
    chk("idle_locked", locked_o, 1);

    pv0 = pv_cnt;
    send_frame(1, VT, -1, -1);                 // F3: all 0xFFF
    #1;
    chk("f3_fd", fd_cnt, 2);
    chk("f3_pv", pv_cnt - pv0, HA * VA);

    nz0 = nz_cnt;
    send_frame(2, VT, -1, -1);                 // F4: single 0xF00 at last pixel
    #1;
    chk("f4_lit", lit_count_o, HA * VA);
    chk("f4_crc", crc_o, model_crc(1));
    chk("f4_nz", nz_cnt - nz0, 1);
    chk("f4_x", nz_x, HA - 1);
    chk("f4_y", nz_y, VA - 1);
    chk("f4_rgb", nz_rgb, 12'hF00);

    send_frame(3, VT, -1, -1);                 // F5: coordinate pattern
    #1;
    chk("f5_fd", fd_cnt, 4);
    chk("f5_lit", lit_count_o, 1);
    chk("f5_crc", crc_o, model_crc(2));

    for (int v = 0; v < 6; v++)                // F6: line 5 one strobe short
      send_line(v, 0, (v == 5) ? HT - 1 : HT, HSW, 0);
    send_line(6, 0, 2, HSW, 0);
    #1;
    chk("short_locked", locked_o, 0);
    chk("short_err", err_o, 3'b001);
    chk("short_fd", fd_cnt, 5);
    chk("short_lit", lit_count_o, HA * VA);
    chk("short_crc", crc_o, model_crc(3));
    send_line(6, 2, HT, HSW, 0);
    send_line(7, 0, HT, HSW, 0);
    send_line(8, 0, HT, HSW, 0);
    send_frame(0, VT, -1, -1);                 // F7
    #1; chk("relock_early", locked_o, 0);
    send_frame(0, VT, -1, -1);                 // F8
    #1;
    chk("relock", locked_o, 1);
    chk("relock_fd", fd_cnt, 5);
    chk("relock_err", err_o, 3'b001);

    send_frame(0, VT, -1, 2);                  // F9: HS width one short
    #1;
    chk("narrow_err", err_o, 3'b011);
    chk("narrow_locked", locked_o, 0);
    chk("narrow_fd", fd_cnt, 6);

    send_frame(0, VT + 1, -1, -1);             // F10: one extra line
    send_frame(0, VT, -1, -1);                 // F11
    #1;
    chk("long_err", err_o, 3'b111);
    chk("long_locked", locked_o, 0);
    send_frame(0, VT, -1, -1);                 // F12
    #1; chk("long_relock", locked_o, 1);

    for (int v = 0; v < 5; v++)                // F13: reset mid-frame
      send_line(v, 0, HT, HSW, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_locked", locked_o, 0);
    chk("mrst_err", err_o, 0);
    chk("mrst_lit", lit_count_o, 0);
    chk("mrst_crc", crc_o, 16'hFFFF);
    chk("mrst_pv", pix_valid_o, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    for (int v = 5; v < VT; v++)
      send_line(v, 0, HT, HSW, 1);
    send_frame(1, VT, -1, -1);                 // F14
    #1; chk("mrst_unlocked", locked_o, 0);
    send_frame(1, VT, -1, -1);                 // F15
    #1; chk("mrst_relock", locked_o, 1);
    fd0 = fd_cnt;
    send_frame(1, VT, -1, -1);                 // F16: reports F15
    #1;
    chk("mrst_fd", fd_cnt - fd0, 1);
    chk("mrst_final_lit", lit_count_o, HA * VA);
    chk("mrst_final_crc", crc_o, model_crc(1));
    chk("mrst_final_err", err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
